// File: rtl/intlv_part_wr32_gen_if.sv
// Bundle of job-control, input-beat and wr32 write-port signals for one part writer.
// The master drives jobs and beats; the slave is the intlv_part_wr32_gen instance.
interface intlv_part_wr32_gen_if #(
    parameter int IN_W  = 8,
    parameter int AW    = 14,
    parameter int CNT_W = 14
);
    logic               start;
    logic               clr;
    logic [CNT_W+4:0]   e_bits;
    logic [AW-1:0]      base_addr;
    logic               in_valid;
    logic [IN_W-1:0]    in_data;
    logic               in_ready;
    logic               mem_busy;
    logic               wr32_en;
    logic [AW-1:0]      wr32_addr;
    logic [31:0]        wr32_data;
    logic [CNT_W-1:0]   E_left32bits_nums;
    logic               busy;
    logic               done;

    modport master (
        output start, clr, e_bits, base_addr, in_valid, in_data, mem_busy,
        input  in_ready, wr32_en, wr32_addr, wr32_data, E_left32bits_nums, busy, done
    );

    modport slave (
        input  start, clr, e_bits, base_addr, in_valid, in_data, mem_busy,
        output in_ready, wr32_en, wr32_addr, wr32_data, E_left32bits_nums, busy, done
    );
endinterface

// File: rtl/intlv_part_wr32_gen.sv
// Per-part word writer: packs an E-bit beat stream into 32-bit words and issues one wr32 pulse per word.
// Define INTLV_WR32_MSB_FIRST_EN to pack MSB-first (first received bit lands in word bit 31).
module intlv_part_wr32_gen #(
    parameter int IN_W  = 8,
    parameter int AW    = 14,
    parameter int CNT_W = 14
) (
    input logic                  clk,
    input logic                  rst_n,
    intlv_part_wr32_gen_if.slave bus
);
    localparam int EW = CNT_W + 5;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [EW-1:0]    rem_q, rem_d;
    logic [31:0]      acc_q, acc_d;
    logic [5:0]       acc_cnt_q, acc_cnt_d;
    logic [31:0]      hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] e_left_q, e_left_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic [5:0]       take;
    logic [31:0]      beat_mask;
    logic [31:0]      acc_next;
    logic             completes;
    logic             in_ready;
    logic             accept;
    logic             issue;

    function automatic logic [31:0] word_order(input logic [31:0] w);
`ifdef INTLV_WR32_MSB_FIRST_EN
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
`else
        return w;
`endif
    endfunction

    // The final beat may carry fewer useful bits than IN_W; the rest are masked off.
    assign take      = (rem_q < EW'(IN_W)) ? rem_q[5:0] : 6'(IN_W);
    assign beat_mask = (take >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << take) - 32'd1);
    assign acc_next  = acc_q | ((32'(bus.in_data) & beat_mask) << acc_cnt_q);
    assign completes = ((acc_cnt_q + take) == 6'd32) || (EW'(take) == rem_q);
    assign in_ready  = (state_q == S_FILL) && (rem_q != '0) && !(hold_full_q && completes);
    assign accept    = bus.in_valid && in_ready;
    assign issue     = (state_q == S_FILL) && hold_full_q && !bus.mem_busy;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        addr_d      = addr_q;
        e_left_d    = e_left_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.e_bits != '0) begin
                        e_left_d    = bus.e_bits[EW-1:5] + CNT_W'(|bus.e_bits[4:0]);
                        rem_d       = bus.e_bits;
                        addr_d      = bus.base_addr;
                        acc_d       = '0;
                        acc_cnt_d   = '0;
                        hold_full_d = 1'b0;
                        state_d     = S_FILL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL: begin
                if (issue) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = hold_q;
                    e_left_d    = e_left_q - 1'b1;
                    addr_d      = addr_q + 1'b1;
                    hold_full_d = 1'b0;
                end
                // A word completing on the issue edge refills hold in the same cycle.
                if (accept) begin
                    rem_d = rem_q - EW'(take);
                    if (completes) begin
                        hold_d      = word_order(acc_next);
                        hold_full_d = 1'b1;
                        acc_d       = '0;
                        acc_cnt_d   = '0;
                    end else begin
                        acc_d     = acc_next;
                        acc_cnt_d = acc_cnt_q + take;
                    end
                end
                if ((rem_q == '0) && !hold_full_q && (acc_cnt_q == '0)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops the job without touching the word counter or raising done.
        if (bus.clr) begin
            state_d     = S_IDLE;
            rem_d       = '0;
            acc_d       = '0;
            acc_cnt_d   = '0;
            hold_full_d = 1'b0;
            wr_en_d     = 1'b0;
            wr_addr_d   = wr_addr_q;
            wr_data_d   = wr_data_q;
            e_left_d    = e_left_q;
            addr_d      = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            addr_q      <= '0;
            e_left_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            addr_q      <= addr_d;
            e_left_q    <= e_left_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.wr32_en           = wr_en_q;
    assign bus.wr32_addr         = wr_addr_q;
    assign bus.wr32_data         = wr_data_q;
    assign bus.E_left32bits_nums = e_left_q;
    assign bus.busy              = (state_q == S_FILL);
    assign bus.done              = (state_q == S_DONE);
endmodule

// File: tb/tb_intlv_part_wr32_gen.sv
// Bench for intlv_part_wr32_gen: table-driven jobs, randomized jobs against a bit-level
// stream model, and directed sequences for mem_busy stalls, empty jobs, reset and abort.
`timescale 1ns/1ps
module tb_intlv_part_wr32_gen;
    localparam int IN_W  = 8;
    localparam int AW    = 14;
    localparam int CNT_W = 14;
    localparam int EW    = CNT_W + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intlv_part_wr32_gen_if #(.IN_W(IN_W), .AW(AW), .CNT_W(CNT_W)) bus ();

    intlv_part_wr32_gen #(.IN_W(IN_W), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [AW-1:0]   exp_addr_q[$];
    logic [31:0]     exp_data_q[$];
    logic [IN_W-1:0] cur_beats[$];
    int              cur_idx;
    int              pulse_cnt;
    int              first_pulse_edge;
    int              lat_edge;
    logic [31:0]     first_data, last_data;
    logic [AW-1:0]   last_addr;

    typedef struct {
        int            e;
        logic [AW-1:0] base;
        logic [7:0]    b0;
        int            nw;
        logic [31:0]   w_first;
        logic [31:0]   w_last;
        logic [AW-1:0] a_last;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {bus.wr32_en, bus.wr32_addr, bus.wr32_data, bus.E_left32bits_nums,
                 bus.busy, bus.done, bus.in_ready}, 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard for write pulses and the word counter.
    initial begin
        logic [AW-1:0]    ea;
        logic [31:0]      ed;
        logic [CNT_W-1:0] prev_eleft;
        logic             prev_busy;
        prev_eleft = '0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (bus.wr32_en) begin
                    if (exp_data_q.size() == 0) begin
                        chk("wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        ed = exp_data_q.pop_front();
                        chk("wr_addr", 64'(bus.wr32_addr), 64'(ea));
                        chk("wr_data", 64'(bus.wr32_data), 64'(ed));
                    end
                    if (pulse_cnt == 0) begin
                        first_data       = bus.wr32_data;
                        first_pulse_edge = cyc;
                    end
                    last_data = bus.wr32_data;
                    last_addr = bus.wr32_addr;
                    pulse_cnt++;
                    chk("eleft_dec", 64'(bus.E_left32bits_nums), 64'(CNT_W'(prev_eleft - 1'b1)));
                end else if (!(bus.busy && !prev_busy) && (bus.E_left32bits_nums != prev_eleft)) begin
                    chk("eleft_hold", 64'(bus.E_left32bits_nums), 64'(prev_eleft));
                end
            end
            prev_eleft = bus.E_left32bits_nums;
            prev_busy  = bus.busy;
        end
    end

    // Reference: the job is a flat bit stream; word i holds stream bits 32i..32i+31, zero-padded.
    task automatic model_build(input int e, input logic [AW-1:0] base);
        int          nw;
        logic [31:0] w;
        nw = (e + 31) / 32;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int j = 0; j < 32; j++) begin
                int b;
                b = i * 32 + j;
                if (b < e) w[j] = cur_beats[b / IN_W][b % IN_W];
            end
            exp_addr_q.push_back(AW'(int'(base) + i));
            exp_data_q.push_back(w);
        end
    endtask

    task automatic start_job(input int e, input logic [AW-1:0] base);
        exp_addr_q.delete();
        exp_data_q.delete();
        model_build(e, base);
        pulse_cnt = 0;
        cur_idx   = 0;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.e_bits    = EW'(e);
        bus.base_addr = base;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drive(input bit valid, input bit mb);
        bus.in_valid = valid && (cur_idx < cur_beats.size());
        bus.in_data  = (cur_idx < cur_beats.size()) ? cur_beats[cur_idx] : '0;
        bus.mem_busy = mb;
    endtask

    task automatic feed_cycles(input int n);
        bit acc;
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 1'b0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) cur_idx++;
            #1;
        end
    endtask

    task automatic fill_beats(input int e, input bit incr, input logic [7:0] b0);
        cur_beats.delete();
        for (int i = 0; i < (e + IN_W - 1) / IN_W; i++)
            cur_beats.push_back(incr ? IN_W'(b0 + 8'(i)) : IN_W'($urandom));
    endtask

    task automatic run_job(input int e, input logic [AW-1:0] base, input int valid_pct,
                           input int busy_pct, input int bs, input int blen);
        int               r, nw, lat_idx;
        bit               got_done, last_checked, win_pulse, acc, mb;
        logic [CNT_W-1:0] eref;
        nw = (e + 31) / 32;
        lat_idx = (cur_beats.size() < 4) ? cur_beats.size() - 1 : 3;
        start_job(e, base);
        r = 0; got_done = 0; last_checked = 0; win_pulse = 0; eref = '0; lat_edge = 0;
        while (!got_done && r < 3000) begin
            mb = (blen > 0 && r >= bs && r < bs + blen) ? 1'b1 : ($urandom_range(99) < busy_pct);
            drive($urandom_range(99) < valid_pct, mb);
            @(negedge clk);
            if (r == 0) begin
                chk("eleft_load", 64'(bus.E_left32bits_nums), 64'(nw));
                chk("busy_high", 64'(bus.busy), 64'd1);
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc && cur_idx == lat_idx) lat_edge = cyc + 1;
            if (blen > 0 && r > bs && r < bs + blen) begin
                if (bus.wr32_en) win_pulse = 1'b1;
                if (r == bs + 1) eref = bus.E_left32bits_nums;
                if (r == bs + blen - 1) begin
                    chk("stall_ready_low", 64'(bus.in_ready), 64'd0);
                    chk("stall_eleft", 64'(bus.E_left32bits_nums), 64'(eref));
                    chk("stall_no_wr", 64'(win_pulse), 64'd0);
                end
            end
            if (cur_idx == cur_beats.size() && !last_checked) begin
                chk("ready_after_last", 64'(bus.in_ready), 64'd0);
                last_checked = 1'b1;
            end
            if (bus.done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk);
                if (acc) cur_idx++;
                #1;
            end
            r++;
        end
        if (!got_done) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("pulse_count", 64'(pulse_cnt), 64'(nw));
            chk("eleft_at_done", 64'(bus.E_left32bits_nums), 64'd0);
            chk("model_drained", 64'(exp_data_q.size()), 64'd0);
            chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_busy = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        tbl[0] = '{64,  14'h0010, 8'h00, 2, 32'h03020100, 32'h07060504, 14'h0011};
        tbl[1] = '{40,  14'h0020, 8'h11, 2, 32'h14131211, 32'h00000015, 14'h0021};
        tbl[2] = '{64,  14'h3FFF, 8'h00, 2, 32'h03020100, 32'h07060504, 14'h0000};
        tbl[3] = '{8,   14'h0100, 8'hA5, 1, 32'h000000A5, 32'h000000A5, 14'h0100};
        tbl[4] = '{33,  14'h0005, 8'hF1, 2, 32'hF4F3F2F1, 32'h00000001, 14'h0006};
        tbl[5] = '{36,  14'h0007, 8'h0F, 2, 32'h1211100F, 32'h00000003, 14'h0008};

        bus.start = 1'b0; bus.clr = 1'b0; bus.e_bits = '0; bus.base_addr = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_beats(tbl[i].e, 1'b1, tbl[i].b0);
            run_job(tbl[i].e, tbl[i].base, 100, 0, 0, 0);
            chk("tbl_first_word", 64'(first_data), 64'(tbl[i].w_first));
            chk("tbl_last_word", 64'(last_data), 64'(tbl[i].w_last));
            chk("tbl_last_addr", 64'(last_addr), 64'(tbl[i].a_last));
            chk("tbl_wr_latency", 64'(first_pulse_edge), 64'(lat_edge + 1));
        end

        // Ten-cycle SRAM stall once the first word is ready.
        fill_beats(128, 1'b0, 8'h00);
        run_job(128, 14'h0200, 100, 0, 2, 10);

        // Empty job: done next cycle, never busy, never writes.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.e_bits = '0; bus.base_addr = 14'h0123;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("empty_done", 64'(bus.done), 64'd1);
        chk("empty_busy", 64'(bus.busy), 64'd0);
        chk("empty_no_wr", 64'(bus.wr32_en), 64'd0);
        @(negedge clk);
        chk("empty_done_drop", 64'(bus.done), 64'd0);
        chk("empty_busy2", 64'(bus.busy), 64'd0);

        // Asynchronous reset mid-job, between clock edges.
        fill_beats(128, 1'b0, 8'h00);
        start_job(128, 14'h0040);
        feed_cycles(8);
        chk("rst_pre_pulses", 64'(pulse_cnt), 64'd1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid_job");
        bus.in_valid = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Abort on the cycle a held word would have been written.
        fill_beats(128, 1'b0, 8'h00);
        start_job(128, 14'h0080);
        feed_cycles(8);
        chk("clr_pre_pulses", 64'(pulse_cnt), 64'd1);
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_eleft_frozen", 64'(bus.E_left32bits_nums), 64'd3);
        chk("clr_no_wr", 64'(bus.wr32_en), 64'd0);
        chk("clr_ready_low", 64'(bus.in_ready), 64'd0);
        chk("clr_busy_low", 64'(bus.busy), 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("clr_no_done", 64'(saw_done), 64'd0);
        chk("clr_eleft_still", 64'(bus.E_left32bits_nums), 64'd3);
        exp_addr_q.delete();
        exp_data_q.delete();
        fill_beats(96, 1'b0, 8'h00);
        run_job(96, 14'h1000, 100, 0, 0, 0);

        // Randomized jobs with input gaps and SRAM back-pressure.
        for (int n = 0; n < 10; n++) begin
            int e;
            e = $urandom_range(300, 1);
            fill_beats(e, 1'b0, 8'h00);
            run_job(e, AW'($urandom), 70, 30, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
